bist_err_logger: RTL and testbench

- Sits directly downstream of the AXI BIST top and consumes its per-error outputs: next_err_flag, next_err_data, exp_data_out, test_main_state.
- Timestamps each error event and stores it as a record in a small FIFO.
- Serialises each record as a framed byte stream over a valid/ready interface toward the board UART transmitter, so that DDR test failures can be logged off-chip without a debugger.

---
 rtl/bist_err_logger_pkg.sv | 26 ++
 rtl/bist_err_logger_if.sv | 9 +
 rtl/bist_err_logger_fifo.sv | 63 ++++++
 rtl/bist_err_logger.sv | 170 +++++++++++++++++
 tb/tb_bist_err_logger.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_err_logger_pkg.sv
// Shared constants, serialiser state encoding and small helpers for the BIST error logger.
package bist_log_pkg;

  localparam int DEF_MEM_DQ_WIDTH = 16;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int REC_W = 8 + 32 + 4 + 2 * DEF_MEM_DQ_WIDTH * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } ser_state_e;

  function automatic int rec_width(input int dq_width);
    return 8 + 32 + 4 + 2 * dq_width * 8;
  endfunction

  function automatic int rec_bytes(input int db);
    return 7 + 2 * db;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/bist_err_logger_if.sv
// Byte stream from the logger toward the UART transmitter (valid/ready).
interface bist_err_logger_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bist_err_logger_fifo.sv
// Single-clock record FIFO; push and pop on the same edge are both honoured.
module bist_log_fifo
  import bist_log_pkg::*;
#(
  parameter int W  = REC_W,
  parameter int AW = 3
) (
  input  logic          core_clk,
  input  logic          core_clk_rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Record storage; contents need no reset since pointers gate every read.
  always_ff @(posedge core_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge core_clk) begin
    if (core_clk_rst || clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/bist_err_logger.sv
// Timestamps BIST error beats into a record FIFO and streams each record as
// A5-framed bytes with a trailing XOR checksum.
module bist_err_logger
  import bist_log_pkg::*;
#(
  parameter int         MEM_DQ_WIDTH = DEF_MEM_DQ_WIDTH,
  parameter int         LOG_DEPTH_AW = 3,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic                      core_clk,
  input  logic                      core_clk_rst,
  input  logic                      next_err_flag,
  input  logic [MEM_DQ_WIDTH*8-1:0] next_err_data,
  input  logic [MEM_DQ_WIDTH*8-1:0] exp_data_out,
  input  logic [3:0]                test_main_state,
  input  logic                      log_clear,
  bist_err_logger_if.master         tx,
  output logic [LOG_DEPTH_AW:0]     log_level,
  output logic [7:0]                drop_cnt,
  output logic                      log_busy
);
  localparam int DW    = MEM_DQ_WIDTH * 8;
  localparam int RW    = rec_width(MEM_DQ_WIDTH);
  localparam int NB    = rec_bytes(MEM_DQ_WIDTH);
  localparam int SW    = NB * 8;
  localparam int IDX_W = $clog2(NB);

  logic [31:0]      ts_r;
  logic [7:0]       seq_r;
  logic [7:0]       drop_cnt_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [RW-1:0]    rec_s;
  logic [RW-1:0]    fifo_rd_s;
  logic [SW-1:0]    stream_s;

  ser_state_e       state_r, state_s;
  logic [SW-1:0]    sreg_r, sreg_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [7:0]       csum_r, csum_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             tx_valid_r, tx_valid_s;
  logic             busy_r;

  assign push_s   = next_err_flag && !fifo_full_s;
  assign rec_s    = {seq_r, ts_r, test_main_state, next_err_data, exp_data_out};
  assign stream_s = {HDR_BYTE, fifo_rd_s[RW-1 -: 40], 4'h0, fifo_rd_s[2*DW +: 4], fifo_rd_s[2*DW-1:0]};

  // Free-running timestamp; survives log_clear so time stays monotonic across flushes.
  always_ff @(posedge core_clk) begin
    if (core_clk_rst) begin
      ts_r <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end

  // Sequence number advances only on accepted records; drop counter saturates.
  always_ff @(posedge core_clk) begin
    if (core_clk_rst || log_clear) begin
      seq_r      <= 8'd0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (push_s) begin
        seq_r <= seq_r + 8'd1;
      end
      if (next_err_flag && fifo_full_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  bist_log_fifo #(
    .W  (RW),
    .AW (LOG_DEPTH_AW)
  ) u_fifo (
    .core_clk     (core_clk),
    .core_clk_rst (core_clk_rst),
    .clr          (log_clear),
    .push         (push_s),
    .push_data    (rec_s),
    .pop          (pop_s),
    .pop_data     (fifo_rd_s),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .level        (log_level)
  );

  // Serialiser next-state: tx_data/tx_valid are computed here and registered so they only change on accept.
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    idx_s      = idx_r;
    csum_s     = csum_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          sreg_s     = stream_s;
          idx_s      = {IDX_W{1'b0}};
          csum_s     = 8'h00;
          tx_data_s  = stream_s[SW-1 -: 8];
          tx_valid_s = 1'b1;
          state_s    = SEND;
        end else begin
          tx_valid_s = 1'b0;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          csum_s = csum_step(csum_r, tx_data_r);
          sreg_s = {sreg_r[SW-9:0], 8'h00};
          idx_s  = idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(NB - 1)) begin
            tx_data_s = csum_step(csum_r, tx_data_r);
            state_s   = CSUM;
          end else begin
            tx_data_s = sreg_r[SW-9 -: 8];
          end
        end else begin
          tx_data_s = tx_data_r;
        end
      end
      CSUM: begin
        if (tx.tx_ready) begin
          tx_valid_s = 1'b0;
          state_s    = IDLE;
        end else begin
          tx_valid_s = 1'b1;
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // Serialiser registers; log_clear abandons any record in flight.
  always_ff @(posedge core_clk) begin
    if (core_clk_rst || log_clear) begin
      state_r    <= IDLE;
      sreg_r     <= {SW{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      csum_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sreg_r     <= sreg_s;
      idx_r      <= idx_s;
      csum_r     <= csum_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign drop_cnt    = drop_cnt_r;
  assign log_busy    = busy_r;

endmodule

// File: tb/tb_bist_err_logger.sv
// Randomised bench for bist_err_logger against a transaction-level reference model.
module tb_bist_err_logger;
  localparam int DB    = 16;
  localparam int DW    = DB * 8;
  localparam int NB    = 7 + 2 * DB;
  localparam int DEPTH = 8;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct packed {
    logic [7:0]    seq;
    logic [31:0]   ts;
    logic [3:0]    st;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } rec_t;

  logic          core_clk;
  logic          core_clk_rst;
  logic          next_err_flag;
  logic [DW-1:0] next_err_data;
  logic [DW-1:0] exp_data_out;
  logic [3:0]    test_main_state;
  logic          log_clear;
  logic [3:0]    log_level;
  logic [7:0]    drop_cnt;
  logic          log_busy;

  bist_err_logger_if tx_if ();

  bist_err_logger dut (
    .core_clk        (core_clk),
    .core_clk_rst    (core_clk_rst),
    .next_err_flag   (next_err_flag),
    .next_err_data   (next_err_data),
    .exp_data_out    (exp_data_out),
    .test_main_state (test_main_state),
    .log_clear       (log_clear),
    .tx              (tx_if),
    .log_level       (log_level),
    .drop_cnt        (drop_cnt),
    .log_busy        (log_busy)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_on   = 1'b0;

  // Reference model state: queue of stored records plus the record being sent.
  rec_t        m_q[$];
  logic [7:0]  m_b[0:NB];
  int          m_rem  = 0;
  logic [7:0]  m_seq  = 8'd0;
  int          m_drop = 0;
  logic [31:0] m_ts   = 32'd0;
  logic [7:0]  acc_q[$];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] ts_v;
    bit          full_v;
    rec_t        r;
    logic [7:0]  x;
    if (core_clk_rst) begin
      m_q.delete();
      m_rem  = 0;
      m_seq  = 8'd0;
      m_drop = 0;
      m_ts   = 32'd0;
    end else begin
      ts_v = m_ts;
      m_ts = m_ts + 32'd1;
      if (log_clear) begin
        m_q.delete();
        m_rem  = 0;
        m_seq  = 8'd0;
        m_drop = 0;
      end else begin
        full_v = (m_q.size() == DEPTH);
        if (m_rem == 0) begin
          if (m_q.size() != 0) begin
            r = m_q.pop_front();
            m_b[0] = HDR;
            m_b[1] = r.seq;
            m_b[2] = r.ts[31:24];
            m_b[3] = r.ts[23:16];
            m_b[4] = r.ts[15:8];
            m_b[5] = r.ts[7:0];
            m_b[6] = {4'h0, r.st};
            for (int i = 0; i < DB; i++) begin
              m_b[7+i]    = r.d[DW-1-8*i -: 8];
              m_b[7+DB+i] = r.e[DW-1-8*i -: 8];
            end
            x = 8'h00;
            for (int i = 0; i < NB; i++) x = x ^ m_b[i];
            m_b[NB] = x;
            m_rem   = NB + 1;
          end
        end else if (tx_if.tx_ready) begin
          m_rem--;
        end
        if (next_err_flag) begin
          if (!full_v) begin
            r = {m_seq, ts_v, test_main_state, next_err_data, exp_data_out};
            m_q.push_back(r);
            m_seq = m_seq + 8'd1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge core_clk);
    model_step();
  end

  // Per-cycle comparison against the model, plus capture of every accepted byte.
  initial forever begin
    @(negedge core_clk);
    if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) acc_q.push_back(tx_if.tx_data);
    if (mdl_on) begin
      chk_val("tx_valid", 64'(tx_if.tx_valid), 64'(m_rem != 0));
      chk_val("log_busy", 64'(log_busy), 64'(m_rem != 0));
      chk_val("log_level", 64'(log_level), 64'(m_q.size()));
      chk_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_rem != 0) chk_val("tx_data", 64'(tx_if.tx_data), 64'(m_b[NB+1-m_rem]));
    end
  end

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [3:0] st);
    next_err_flag   = 1'b1;
    next_err_data   = d;
    exp_data_out    = e;
    test_main_state = st;
    tick();
    next_err_flag = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready);
    bit done_v = 1'b0;
    for (int i = 0; i < budget && !done_v; i++) begin
      if (rnd_ready) tx_if.tx_ready = ($urandom_range(0, 1) == 1);
      tick();
      done_v = !log_busy && (log_level == 4'd0);
    end
    chk_val("idle_reached", 64'(done_v), 64'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit done_v = 1'b0;
    for (int i = 0; i < budget && !done_v; i++) begin
      tick();
      done_v = (acc_q.size() >= n);
    end
    chk_val("bytes_reached", 64'(done_v), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_valid"}, 64'(tx_if.tx_valid), 64'd0);
    chk_val({tag, "_data"},  64'(tx_if.tx_data),  64'd0);
    chk_val({tag, "_level"}, 64'(log_level),      64'd0);
    chk_val({tag, "_drop"},  64'(drop_cnt),       64'd0);
    chk_val({tag, "_busy"},  64'(log_busy),       64'd0);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    logic [7:0]    x;
    logic [31:0]   ts_a;
    logic [31:0]   ts_b;
    logic [DW-1:0] one_w;
    core_clk_rst    = 1'b1;
    next_err_flag   = 1'b0;
    next_err_data   = '0;
    exp_data_out    = '0;
    test_main_state = 4'h0;
    log_clear       = 1'b0;
    tx_if.tx_ready  = 1'b1;
    one_w           = '0;
    one_w[0]        = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    mdl_on       = 1'b1;
    core_clk_rst = 1'b0;

    // Single record, ready held high; check latency and framing.
    repeat (8) tick();
    acc_q.delete();
    pulse(one_w, '0, 4'h3);
    chk_val("lat_edge_n", 64'(tx_if.tx_valid), 64'd0);
    tick();
    chk_val("lat_edge_n1", 64'(tx_if.tx_valid), 64'd1);
    wait_idle(200, 1'b0);
    chk_val("s1_len", 64'(acc_q.size()), 64'(NB + 1));
    if (acc_q.size() == NB + 1) begin
      chk_val("s1_hdr", 64'(acc_q[0]), 64'hA5);
      chk_val("s1_seq", 64'(acc_q[1]), 64'h00);
      chk_val("s1_state", 64'(acc_q[6]), 64'h03);
      chk_val("s1_data_lsb", 64'(acc_q[22]), 64'h01);
      chk_val("s1_exp_lsb", 64'(acc_q[38]), 64'h00);
      x = 8'h00;
      foreach (acc_q[i]) x = x ^ acc_q[i];
      chk_val("s1_csum", 64'(x), 64'h00);
    end

    // Same record under random backpressure.
    acc_q.delete();
    pulse(one_w, '0, 4'h3);
    wait_idle(2000, 1'b1);
    chk_val("s2_len", 64'(acc_q.size()), 64'(NB + 1));
    if (acc_q.size() == NB + 1) begin
      chk_val("s2_seq", 64'(acc_q[1]), 64'h01);
      chk_val("s2_data_lsb", 64'(acc_q[22]), 64'h01);
    end

    // Push and pop on the same edge keeps the level at one.
    tx_if.tx_ready = 1'b1;
    pulse(rnd_word(), rnd_word(), 4'h5);
    pulse(rnd_word(), rnd_word(), 4'h6);
    chk_val("pushpop_level", 64'(log_level), 64'd1);
    wait_idle(300, 1'b0);

    // Overflow: one record parks in the stalled serialiser, eight fill the FIFO, two drop.
    log_clear = 1'b1;
    tick();
    log_clear      = 1'b0;
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 11; i++) pulse(rnd_word(), rnd_word(), 4'(i));
    tick();
    chk_val("ovf_level", 64'(log_level), 64'd8);
    chk_val("ovf_drop", 64'(drop_cnt), 64'd2);
    acc_q.delete();
    tx_if.tx_ready = 1'b1;
    wait_idle(1000, 1'b0);
    chk_val("ovf_len", 64'(acc_q.size()), 64'(9 * (NB + 1)));
    if (acc_q.size() == 9 * (NB + 1)) begin
      for (int k = 0; k < 9; k++) begin
        chk_val("ovf_seq", 64'(acc_q[k*(NB+1)+1]), 64'(k));
        if (k > 0) begin
          ts_a = {acc_q[(k-1)*(NB+1)+2], acc_q[(k-1)*(NB+1)+3], acc_q[(k-1)*(NB+1)+4], acc_q[(k-1)*(NB+1)+5]};
          ts_b = {acc_q[k*(NB+1)+2], acc_q[k*(NB+1)+3], acc_q[k*(NB+1)+4], acc_q[k*(NB+1)+5]};
          chk_val("ovf_ts_inc", 64'(ts_b > ts_a), 64'd1);
        end
      end
    end

    // Drop counter saturation.
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) pulse(rnd_word(), rnd_word(), 4'hA);
    chk_val("sat_drop", 64'(drop_cnt), 64'd255);
    for (int i = 0; i < 5; i++) pulse(rnd_word(), rnd_word(), 4'hB);
    chk_val("sat_hold", 64'(drop_cnt), 64'd255);

    // log_clear part-way through a record.
    log_clear = 1'b1;
    tick();
    log_clear      = 1'b0;
    tx_if.tx_ready = 1'b1;
    acc_q.delete();
    pulse(rnd_word(), rnd_word(), 4'h7);
    wait_bytes(5, 100);
    log_clear = 1'b1;
    tick();
    log_clear = 1'b0;
    chk_val("clr_valid", 64'(tx_if.tx_valid), 64'd0);
    chk_val("clr_level", 64'(log_level), 64'd0);
    acc_q.delete();
    pulse(rnd_word(), rnd_word(), 4'h8);
    wait_idle(200, 1'b0);
    if (acc_q.size() == NB + 1) chk_val("clr_seq", 64'(acc_q[1]), 64'h00);
    else chk_val("clr_len", 64'(acc_q.size()), 64'(NB + 1));

    // Reset part-way through a record.
    acc_q.delete();
    pulse(rnd_word(), rnd_word(), 4'h9);
    wait_bytes(5, 100);
    core_clk_rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    core_clk_rst = 1'b0;

    // Random traffic, backpressure and occasional flushes.
    for (int i = 0; i < 4000; i++) begin
      next_err_flag   = ($urandom_range(0, 3) == 0);
      next_err_data   = rnd_word();
      exp_data_out    = rnd_word();
      test_main_state = 4'($urandom_range(0, 15));
      tx_if.tx_ready  = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      log_clear       = ($urandom_range(0, 299) == 0);
      tick();
    end
    next_err_flag  = 1'b0;
    log_clear      = 1'b0;
    tx_if.tx_ready = 1'b1;
    wait_idle(1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
